// File: rtl/tlul_host_pkg.sv
// Local types and helpers for the TL-UL host adapter.
package tlul_host_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } host_rsp_t;

  // Pointer width for the in-flight slots; never narrower than one bit.
  function automatic int SrcIdWidth(input int max_outstanding);
    return (max_outstanding <= 2) ? 1 : $clog2(max_outstanding);
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by hosts and devices on the link.
package tlul_pkg;

  localparam int TL_AW   = 32;
  localparam int TL_DW   = 32;
  localparam int TL_DBW  = TL_DW / 8;
  localparam int TL_AIW  = 8;
  localparam int TL_DIW  = 1;
  localparam int TL_SZW  = 2;
  localparam int TL_AUW  = 14;
  localparam int TL_DUW  = 7;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef logic [TL_AUW-1:0] tl_a_user_t;
  localparam tl_a_user_t TL_A_USER_DEFAULT = '0;

  typedef struct packed {
    logic               a_valid;
    tl_a_op_e           a_opcode;
    logic [2:0]         a_param;
    logic [TL_SZW-1:0]  a_size;
    logic [TL_AIW-1:0]  a_source;
    logic [TL_AW-1:0]   a_address;
    logic [TL_DBW-1:0]  a_mask;
    logic [TL_DW-1:0]   a_data;
    tl_a_user_t         a_user;
    logic               d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic               d_valid;
    tl_d_op_e           d_opcode;
    logic [2:0]         d_param;
    logic [TL_SZW-1:0]  d_size;
    logic [TL_AIW-1:0]  d_source;
    logic [TL_DIW-1:0]  d_sink;
    logic [TL_DW-1:0]   d_data;
    logic [TL_DUW-1:0]  d_user;
    logic               d_error;
    logic               a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_tracker.sv
// In-order bookkeeping of in-flight TL-UL transactions: pointers, count, read flags.
module tlul_host_tracker
  import tlul_pkg::*;
  import tlul_host_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int SrcIdBase      = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              a_fire_i,
  input  logic              a_is_read_i,
  input  logic              d_fire_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [TL_AIW-1:0] issue_source_o,
  output logic [TL_AIW-1:0] exp_source_o,
  output tl_d_op_e          exp_opcode_o,
  output logic              exp_read_o
);

  localparam int PtrW = SrcIdWidth(MaxOutstanding);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [PtrW-1:0]           issue_ptr_q, issue_ptr_d;
  logic [PtrW-1:0]           resp_ptr_q, resp_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [MaxOutstanding-1:0] is_read_q, is_read_d;
  logic                      d_accept;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MaxOutstanding - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o   = (count_q == CntW'(MaxOutstanding));
  assign empty_o  = (count_q == '0);
  // A response with nothing outstanding is spurious and must not move any state.
  assign d_accept = d_fire_i & ~empty_o;

  always_comb begin
    issue_ptr_d = issue_ptr_q;
    resp_ptr_d  = resp_ptr_q;
    count_d     = count_q;
    is_read_d   = is_read_q;
    if (a_fire_i) begin
      is_read_d[issue_ptr_q] = a_is_read_i;
      issue_ptr_d            = next_ptr(issue_ptr_q);
    end
    if (d_accept) begin
      resp_ptr_d = next_ptr(resp_ptr_q);
    end
    case ({a_fire_i, d_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_ptr_q <= '0;
      resp_ptr_q  <= '0;
      count_q     <= '0;
      is_read_q   <= '0;
    end else begin
      issue_ptr_q <= issue_ptr_d;
      resp_ptr_q  <= resp_ptr_d;
      count_q     <= count_d;
      is_read_q   <= is_read_d;
    end
  end

  assign issue_source_o = TL_AIW'(SrcIdBase) + TL_AIW'(issue_ptr_q);
  assign exp_source_o   = TL_AIW'(SrcIdBase) + TL_AIW'(resp_ptr_q);
  assign exp_read_o     = is_read_q[resp_ptr_q];
  assign exp_opcode_o   = exp_read_o ? AccessAckData : AccessAck;

  count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CntW'(MaxOutstanding));

endmodule

// File: rtl/tlul_host_adapter.sv
// TL-UL bus initiator: req/gnt register accesses in, A-channel out, checked responses back.
module tlul_host_adapter
  import tlul_pkg::*;
  import tlul_host_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int SrcIdBase      = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        idle_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  logic              full, empty, a_valid, a_fire, d_fire, exp_read;
  logic [TL_AIW-1:0] issue_source, exp_source;
  tl_d_op_e          exp_opcode;
  host_rsp_t         rsp_q, rsp_d;
  logic              rvalid_q, rvalid_d;
  logic              unused_tl;

  tlul_host_tracker #(
    .MaxOutstanding (MaxOutstanding),
    .SrcIdBase      (SrcIdBase)
  ) u_tracker (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .a_fire_i       (a_fire),
    .a_is_read_i    (~we_i),
    .d_fire_i       (d_fire),
    .full_o         (full),
    .empty_o        (empty),
    .issue_source_o (issue_source),
    .exp_source_o   (exp_source),
    .exp_opcode_o   (exp_opcode),
    .exp_read_o     (exp_read)
  );

  // Full check uses the registered count, so a freed slot is usable next cycle.
  assign a_valid = req_i & ~full;
  assign a_fire  = a_valid & tl_i.a_ready;
  assign d_fire  = tl_i.d_valid;
  assign gnt_o   = a_fire;
  assign idle_o  = empty;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    if (!we_i) begin
      tl_o.a_opcode = Get;
    end else if (be_i == 4'hF) begin
      tl_o.a_opcode = PutFullData;
    end else begin
      tl_o.a_opcode = PutPartialData;
    end
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = issue_source;
    tl_o.a_address = {addr_i[31:2], 2'b00};
    tl_o.a_mask    = we_i ? be_i : 4'hF;
    tl_o.a_data    = we_i ? wdata_i : 32'h0;
    tl_o.a_user    = TL_A_USER_DEFAULT;
    tl_o.d_ready   = 1'b1;
  end

  always_comb begin
    rvalid_d = d_fire;
    rsp_d    = rsp_q;
    if (d_fire) begin
      if (empty) begin
        rsp_d.rdata = 32'h0;
        rsp_d.err   = 1'b1;
      end else begin
        rsp_d.rdata = exp_read ? tl_i.d_data : 32'h0;
        rsp_d.err   = tl_i.d_error | (tl_i.d_source != exp_source)
                    | (tl_i.d_opcode != exp_opcode);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rsp_q    <= rsp_d;
    end
  end

  // Masking keeps a pulse registered just before reset from showing during it.
  assign rvalid_o = rvalid_q & ~rst_i;
  assign rdata_o  = rsp_q.rdata;
  assign err_o    = rsp_q.err;

  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

  a_valid_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (tl_o.a_valid && !tl_i.a_ready) |=>
      (tl_o.a_valid && $stable(tl_o.a_address) && $stable(tl_o.a_opcode)
       && $stable(tl_o.a_mask) && $stable(tl_o.a_data)));
  no_rvalid_in_reset: assert property (@(posedge clk_i) rst_i |-> !rvalid_o);
  rsp_known: assert property (@(posedge clk_i) disable iff (rst_i)
    !$isunknown({rvalid_o, err_o}));

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Directed bench for tlul_host_adapter with a response scoreboard.
module tb_tlul_host_adapter;
  import tlul_pkg::*;
  import tlul_host_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        idle_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int tests = 0;
  int fails = 0;
  host_rsp_t sb[$];

  always #5 clk = ~clk;

  tlul_host_adapter #(.MaxOutstanding(2), .SrcIdBase(0)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .idle_o   (idle_o),
    .tl_o     (tl_o),
    .tl_i     (tl_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] be);
    addr_i  = a;
    we_i    = w;
    wdata_i = wd;
    be_i    = be;
    req_i   = 1'b1;
    #1;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (!gnt_o && n < 20) begin
      tick();
      n++;
    end
    check(tag, gnt_o, 1'b1);
    tick();
    req_i = 1'b0;
  endtask

  task automatic respond(input tl_d_op_e op, input int src, input logic [31:0] data,
                         input logic derr, input logic [31:0] exp_rdata, input logic exp_err);
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = op;
    tl_i.d_source = 8'(src);
    tl_i.d_data   = data;
    tl_i.d_error  = derr;
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    tick();
    tl_i.d_valid  = 1'b0;
    tl_i.d_error  = 1'b0;
    check("rvalid_pulse", rvalid_o, 1'b1);
    tick();
    check("rvalid_low", rvalid_o, 1'b0);
    check("rdata_hold", rdata_o, exp_rdata);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Response monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i && rvalid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", rvalid_o, 1'b0);
      end else begin
        host_rsp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rdata_o, e.rdata);
        check("rsp_err", err_o, e.err);
        $display("[TB] rsp rdata=%h err=%0b (exp %h/%0b)", rdata_o, err_o, e.rdata, e.err);
      end
    end
  end

  initial begin
    rst_i   = 1'b1;
    req_i   = 1'b0;
    addr_i  = '0;
    we_i    = 1'b0;
    wdata_i = '0;
    be_i    = '0;
    tl_i    = '0;
    tl_i.a_ready = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_gnt", gnt_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_err", err_o, 1'b0);
    check("rst_idle", idle_o, 1'b1);
    check("rst_a_valid", tl_o.a_valid, 1'b0);
    check("d_ready", tl_o.d_ready, 1'b1);

    // Read; low address bits must be dropped
    drive_req(32'h4000_0013, 1'b0, 32'hFFFF_FFFF, 4'h0);
    check("rd_opcode", tl_o.a_opcode, Get);
    check("rd_addr", tl_o.a_address, 32'h4000_0010);
    check("rd_mask", tl_o.a_mask, 4'hF);
    check("rd_data", tl_o.a_data, 32'h0);
    check("rd_size", tl_o.a_size, 2'd2);
    check("rd_src", tl_o.a_source, 8'd0);
    wait_gnt("rd_gnt");
    check("rd_busy", idle_o, 1'b0);
    tick();
    tick();
    respond(AccessAckData, 0, 32'hA5A5_0003, 1'b0, 32'hA5A5_0003, 1'b0);
    check("rd_idle", idle_o, 1'b1);
    $display("[TB] read done");

    // Partial write
    drive_req(32'h4000_0020, 1'b1, 32'h0000_BEEF, 4'b0011);
    check("pw_opcode", tl_o.a_opcode, PutPartialData);
    check("pw_mask", tl_o.a_mask, 4'b0011);
    check("pw_data", tl_o.a_data, 32'h0000_BEEF);
    check("pw_src", tl_o.a_source, 8'd1);
    wait_gnt("pw_gnt");
    respond(AccessAck, 1, 32'hDEAD_0000, 1'b0, 32'h0, 1'b0);
    $display("[TB] partial write done");

    // Full write
    drive_req(32'h4000_0024, 1'b1, 32'h1234_5678, 4'hF);
    check("fw_opcode", tl_o.a_opcode, PutFullData);
    check("fw_src", tl_o.a_source, 8'd0);
    wait_gnt("fw_gnt");
    respond(AccessAck, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    $display("[TB] full write done");

    // Back-pressure / full with fresh pointers
    do_reset();
    drive_req(32'h0000_0100, 1'b0, 32'h0, 4'h0);
    check("full_g0", gnt_o, 1'b1);
    check("full_s0", tl_o.a_source, 8'd0);
    tick();
    drive_req(32'h0000_0104, 1'b0, 32'h0, 4'h0);
    check("full_g1", gnt_o, 1'b1);
    check("full_s1", tl_o.a_source, 8'd1);
    tick();
    drive_req(32'h0000_0108, 1'b0, 32'h0, 4'h0);
    check("full_av", tl_o.a_valid, 1'b0);
    check("full_g2", gnt_o, 1'b0);
    tick();
    check("full_av_hold", tl_o.a_valid, 1'b0);
    tl_i.d_valid  = 1'b1;
    tl_i.d_opcode = AccessAckData;
    tl_i.d_source = 8'd0;
    tl_i.d_data   = 32'h1111_1111;
    sb.push_back('{rdata: 32'h1111_1111, err: 1'b0});
    #1;
    check("full_same_cycle", gnt_o, 1'b0);
    tick();
    tl_i.d_valid = 1'b0;
    #1;
    check("full_next_g", gnt_o, 1'b1);
    check("full_next_s", tl_o.a_source, 8'd0);
    tick();
    req_i = 1'b0;
    respond(AccessAckData, 1, 32'h2222_2222, 1'b0, 32'h2222_2222, 1'b0);
    respond(AccessAckData, 0, 32'h3333_3333, 1'b0, 32'h3333_3333, 1'b0);
    $display("[TB] full/back-pressure done");

    // Error cases (next issue source is 1)
    drive_req(32'h0000_0200, 1'b0, 32'h0, 4'h0);
    check("e1_src", tl_o.a_source, 8'd1);
    wait_gnt("e1_gnt");
    respond(AccessAckData, 1, 32'h4444_4444, 1'b1, 32'h4444_4444, 1'b1);
    drive_req(32'h0000_0204, 1'b0, 32'h0, 4'h0);
    check("e2_src", tl_o.a_source, 8'd0);
    wait_gnt("e2_gnt");
    respond(AccessAckData, 1, 32'h5555_5555, 1'b0, 32'h5555_5555, 1'b1);
    drive_req(32'h0000_0208, 1'b0, 32'h0, 4'h0);
    wait_gnt("e3_gnt");
    respond(AccessAck, 1, 32'h0, 1'b0, 32'h0, 1'b1);
    $display("[TB] error cases done");

    // Spurious response; pointers must stay put
    check("sp_idle_pre", idle_o, 1'b1);
    respond(AccessAckData, 0, 32'h7777_7777, 1'b0, 32'h0, 1'b1);
    check("sp_idle_post", idle_o, 1'b1);
    drive_req(32'h0000_0300, 1'b0, 32'h0, 4'h0);
    check("sp_next_src", tl_o.a_source, 8'd0);
    wait_gnt("sp_next_gnt");
    respond(AccessAckData, 0, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 1'b0);
    $display("[TB] spurious done");

    // Reset mid-flight
    drive_req(32'h0000_0400, 1'b0, 32'h0, 4'h0);
    wait_gnt("rm_g0");
    drive_req(32'h0000_0404, 1'b0, 32'h0, 4'h0);
    wait_gnt("rm_g1");
    check("rm_busy", idle_o, 1'b0);
    do_reset();
    #1;
    check("rm_idle", idle_o, 1'b1);
    check("rm_av", tl_o.a_valid, 1'b0);
    respond(AccessAckData, 1, 32'h8888_8888, 1'b0, 32'h0, 1'b1);
    check("rm_idle_after", idle_o, 1'b1);
    drive_req(32'h0000_0500, 1'b0, 32'h0, 4'h0);
    check("rm_new_src", tl_o.a_source, 8'd0);
    wait_gnt("rm_new_gnt");
    respond(AccessAckData, 0, 32'h9999_9999, 1'b0, 32'h9999_9999, 1'b0);
    $display("[TB] reset mid-flight done");

    repeat (3) tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tlul_host_adapter.md
Name: tlul_host_adapter

Overview:
- Bus initiator: converts a simple req/gnt register-access interface from a local controller into TL-UL A-channel requests.
- Returns D-channel responses to the controller, in order, with error flagging.
- It is the host end of the same TL-UL link that `gpio` and the other peripherals terminate as devices.
- Sits between a small sequencer (boot config, test master) and the crossbar.

Parameters:
- MaxOutstanding, 2, number of in-flight transactions; power of two, 1..8.
- SrcIdBase, 0, base value for a_source; IDs used are SrcIdBase..SrcIdBase+MaxOutstanding-1.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- req_i  input  1  access request; held with stable fields until gnt_o
- gnt_o  output  1  request accepted this cycle (A-channel handshake)
- addr_i  input  32  byte address; bits [1:0] ignored
- we_i  input  1  1 = write, 0 = read
- wdata_i  input  32  write data
- be_i  input  4  byte enables for writes
- rvalid_o  output  1  one-cycle response pulse
- rdata_o  output  32  read data; 0 for write responses
- err_o  output  1  response error; qualified by rvalid_o
- idle_o  output  1  no transactions outstanding
- tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host-to-device
- tl_i  input  tlul_pkg::tl_d2h_t  TL-UL device-to-host

Behaviour:
- Reset is synchronous on rst_i. Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, idle_o=1.
  - tl_o.a_valid=0.
  - Outstanding count, issue pointer and response pointer all 0.
- A channel:
  - a_valid = req_i & (outstanding < MaxOutstanding). Combinational, no added latency.
  - gnt_o = a_valid & tl_i.a_ready.
  - Opcode:
    - we_i & be_i==4'hF: PutFullData.
    - we_i & other be_i: PutPartialData.
    - !we_i: Get.
  - a_address = {addr_i[31:2],2'b00}; a_size = 2.
  - a_mask = we_i ? be_i : 4'hF; a_data = we_i ? wdata_i : 0.
  - a_source = SrcIdBase + issue pointer; a_param = 0; a_user = tlul_pkg::TL_A_USER_DEFAULT.
- D channel:
  - d_ready is constantly 1.
- Tracking:
  - On each A handshake, store is_read[issue_ptr] = !we_i, then increment issue_ptr modulo MaxOutstanding.
  - Outstanding count: +1 on A handshake, -1 on D handshake. Both in the same cycle leaves it unchanged.
  - idle_o = (outstanding == 0).
- Response, registered with 1-cycle latency from the D handshake:
  - rvalid_o=1 in the cycle after d_valid.
  - rdata_o = is_read[resp_ptr] ? d_data : 0.
  - err_o = d_error | (d_source != SrcIdBase+resp_ptr) | opcode mismatch.
  - Opcode mismatch: read expects AccessAckData, write expects AccessAck.
  - resp_ptr increments modulo MaxOutstanding.
  - rvalid_o is a single-cycle pulse; rdata_o and err_o hold until the next response.
- Spurious response (d_valid while outstanding==0):
  - Still produces rvalid_o=1, err_o=1, rdata_o=0.
  - Counters and pointers unchanged.
- Full: with outstanding==MaxOutstanding, a_valid=0 and gnt_o=0 regardless of a_ready. A request becomes grantable in the same cycle a D handshake frees a slot? No. The full check uses the registered count, so the request issues the following cycle.
- Reset mid-operation:
  - All tracking is cleared.
  - Responses arriving after reset are treated as spurious.
- Protocol assertions:
  - Once a_valid rises, it stays high with stable fields until a_ready.
  - rvalid_o never high during rst_i.
  - Outstanding count never exceeds MaxOutstanding.
  - rvalid_o and err_o known out of reset.

Decomposition:
- TL-UL opcodes, structs and the A-user default come from tlul_pkg.
- A local package tlul_host_pkg holds a response struct {rdata, err} and the SrcIdWidth function (clog2 of MaxOutstanding, minimum 1).
- One natural sub-module: tlul_host_tracker.
  - Contains the issue/response pointers, outstanding counter and is_read array.
  - Outputs full, empty, expected source and expected opcode.
  - The top holds A-channel muxing and the response register.

Test Plan:
- Read: req_i with addr_i=0x40000010, we_i=0, device returns AccessAckData d_data=0xA5A5_0003 after 2 cycles -> a_opcode=Get, a_address=0x40000010, a_mask=4'hF; rvalid_o 1 cycle after d_valid; rdata_o=0xA5A50003, err_o=0.
- Partial write: we_i=1, be_i=4'b0011, wdata_i=0x0000_BEEF, device returns AccessAck -> a_opcode=PutPartialData, a_mask=4'b0011; response has rdata_o=0, err_o=0.
- Back-pressure and full, MaxOutstanding=2: a_ready=1, device stalls D, 3 back-to-back requests -> gnt_o for the first two with a_source 0 then 1; third held (a_valid=0). After the first D handshake, the third is granted the next cycle with a_source=0.
- Errors:
  - Response d_error=1 -> err_o=1.
  - Response d_source=1 while 0 is expected -> err_o=1.
  - AccessAck returned for a Get -> err_o=1.
- Spurious response: d_valid with idle_o=1 -> rvalid_o=1, err_o=1, rdata_o=0; idle_o stays 1.
- Reset mid-flight: 2 outstanding, pulse rst_i for 1 cycle -> idle_o=1, a_valid=0. A following stale response yields err_o=1, and a new read then issues with a_source=0.
